rf_wb_arbiter: RTL and testbench

- Controller for the shared 32x32 register file. It multiplexes the file's single write port between NUM_REQ writeback sources (ALU, load/store unit, mul/div) using round-robin arbitration with valid/ready handshakes.
- It keeps a per-register pending-write scoreboard. The issue stage uses it to detect RAW/WAW hazards on the two read ports.
- Sits between the execution units and the register file write port. Drives the file's write number, write data and write enable directly.

---
 rtl/rf_wb_arbiter_pkg.sv | 14 +
 rtl/rf_wb_arbiter_rr_arbiter.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 86 ++++++++
 tb/tb_rf_wb_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: requester indices and default sizes.
// Per-requester buses are packed with requester i at bits [i*W +: W], where W is ADDR_W or DATA_W.
package rf_wb_arbiter_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int REG_NUM_DEF = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MDU = 2;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin grant generator: one-hot grant to the first valid requester at or after the pointer.
// Grant is combinational; the pointer moves past the winner whenever advance_i is high.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic             found;

  // Distance i from the pointer picks requester j; first hit wins.
  always_comb begin
    grant_o = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && valid_i[j] &&
            ((int'(ptr_q) + i == j) || (int'(ptr_q) + i == j + N))) begin
          found      = 1'b1;
          grant_o[j] = 1'b1;
          win_idx    = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (win_idx == IDX_W'(N - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with per-register pending-write scoreboard for hazard detection.
// Write happens on the handshake edge (0-cycle latency); scoreboard updates are registered.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int REG_NUM = REG_NUM_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        wr_en,
  output logic [ADDR_W-1:0]           wr_num,
  output logic [DATA_W-1:0]           wr_data,
  input  logic                        issue_en,
  input  logic [ADDR_W-1:0]           issue_rd,
  input  logic [ADDR_W-1:0]           rs1,
  input  logic [ADDR_W-1:0]           rs2,
  output logic                        hazard,
  output logic [REG_NUM-1:0]          busy_vec,
  output logic                        sb_err
);

  logic [NUM_REQ-1:0] gnt;
  logic               hs;
  logic [ADDR_W-1:0]  gnt_rd;
  logic [DATA_W-1:0]  gnt_data;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               sb_err_q, sb_err_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (req_valid),
    .advance_i (hs),
    .grant_o   (gnt)
  );

  // A grant always lands on a valid requester, so any grant is a handshake.
  assign hs = |gnt;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_rd   = req_rd[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = rst_n ? gnt : '0;
  assign wr_en     = rst_n & hs & (gnt_rd != '0);
  assign wr_num    = rst_n ? gnt_rd : '0;
  assign wr_data   = rst_n ? gnt_data : '0;

  // Set after clear: an issue to the same register is newer than the retiring write.
  always_comb begin
    busy_d = busy_q;
    if (hs && gnt_rd != '0)          busy_d[gnt_rd]   = 1'b0;
    if (issue_en && issue_rd != '0)  busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign hazard   = busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd];
  assign sb_err_d = sb_err_q | (issue_en & hazard);
  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: table of per-cycle vectors with a write-port scoreboard queue,
// followed by hand-written reset sequences.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam logic [31:0] DA = 32'hA000_0001;
  localparam logic [31:0] DB = 32'hB000_0002;
  localparam logic [31:0] DC = 32'hC000_0003;
  localparam logic [31:0] D5 = 32'h5555_0005;
  localparam logic [31:0] E7 = 32'h7777_0007;
  localparam logic [31:0] DBEEF = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        wr_en;
  logic [4:0]  wr_num;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        hazard;
  logic [31:0] busy_vec;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .hazard(hazard), .busy_vec(busy_vec), .sb_err(sb_err)
  );

  typedef struct {
    logic [2:0]  vld;
    logic [4:0]  r1;  logic [31:0] d1;
    logic [4:0]  r0;  logic [31:0] d0;
    logic        iss; logic [4:0]  ird; logic [4:0] s1; logic [4:0] s2;
    logic [2:0]  rdy; logic        wen; logic [4:0] wnum; logic [31:0] wdat;
    logic        haz; logic [31:0] busy; logic err;
  } vec_t;

  typedef struct {
    logic [2:0]  rdy;
    logic        wen;
    logic [4:0]  num;
    logic [31:0] dat;
  } wr_t;

  vec_t tbl[20];
  wr_t  exp_q[$];

  function automatic vec_t mk(
    input logic [2:0] vld, input logic [4:0] r1, input logic [31:0] d1,
    input logic [4:0] r0, input logic [31:0] d0,
    input logic iss, input logic [4:0] ird, input logic [4:0] s1, input logic [4:0] s2,
    input logic [2:0] rdy, input logic wen, input logic [4:0] wnum, input logic [31:0] wdat,
    input logic haz, input logic [31:0] busy, input logic err);
    vec_t v;
    v.vld = vld; v.r1 = r1; v.d1 = d1; v.r0 = r0; v.d0 = d0;
    v.iss = iss; v.ird = ird; v.s1 = s1; v.s2 = s2;
    v.rdy = rdy; v.wen = wen; v.wnum = wnum; v.wdat = wdat;
    v.haz = haz; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    req_valid = v.vld;
    req_rd    = {5'd3, v.r1, v.r0};
    req_data  = {DC, v.d1, v.d0};
    issue_en  = v.iss;
    issue_rd  = v.ird;
    rs1       = v.s1;
    rs2       = v.s2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wr_t e;
    // Fields: vld, r1, d1, r0, d0, iss, ird, rs1, rs2 | rdy, wen, wnum, wdat, haz, busy, err
    tbl[0]  = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd1, DA,    1'b0, 32'h00, 1'b0);
    tbl[1]  = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd2, DB,    1'b0, 32'h00, 1'b0);
    tbl[2]  = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 5'd3, DC,    1'b0, 32'h00, 1'b0);
    tbl[3]  = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b001, 1'b1, 5'd1, DA,    1'b0, 32'h00, 1'b0);
    tbl[4]  = mk(3'b010, 5'd0, DBEEF, 5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b0, 5'd0, DBEEF, 1'b0, 32'h00, 1'b0);
    tbl[5]  = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 5'd3, DC,    1'b0, 32'h00, 1'b0);
    tbl[6]  = mk(3'b000, 5'd2, DB,    5'd1, DA, 1'b1, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b0);
    tbl[7]  = mk(3'b000, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b1, 32'h20, 1'b0);
    tbl[8]  = mk(3'b010, 5'd5, D5,    5'd1, DA, 1'b0, 5'd0, 5'd5, 5'd0, 3'b010, 1'b1, 5'd5, D5,    1'b1, 32'h20, 1'b0);
    tbl[9]  = mk(3'b000, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd5, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b0);
    tbl[10] = mk(3'b000, 5'd2, DB,    5'd1, DA, 1'b1, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h00, 1'b0);
    tbl[11] = mk(3'b001, 5'd2, DB,    5'd7, E7, 1'b1, 5'd7, 5'd0, 5'd0, 3'b001, 1'b1, 5'd7, E7,    1'b1, 32'h80, 1'b0);
    tbl[12] = mk(3'b000, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd7, 3'b000, 1'b0, 5'd0, 32'h0, 1'b1, 32'h80, 1'b1);
    tbl[13] = mk(3'b010, 5'd2, DB,    5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b010, 1'b1, 5'd2, DB,    1'b0, 32'h80, 1'b1);
    for (int k = 14; k < 19; k++)
      tbl[k] = mk(3'b100, 5'd2, DB,   5'd1, DA, 1'b0, 5'd0, 5'd0, 5'd0, 3'b100, 1'b1, 5'd3, DC,    1'b0, 32'h80, 1'b1);
    tbl[19] = mk(3'b111, 5'd2, DB,    5'd1, DA, 1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 1'b1, 5'd1, DA,    1'b0, 32'h80, 1'b1);

    // Reset with requests pending: outputs must stay quiet.
    rst_n = 1'b0;
    apply(tbl[0]);
    #12;
    chk("reset ready", 32'(req_ready), 32'h0);
    chk("reset wr_en", 32'(wr_en), 32'h0);
    chk("reset wr_num", 32'(wr_num), 32'h0);
    chk("reset wr_data", wr_data, 32'h0);
    chk("reset busy", busy_vec, 32'h0);
    chk("reset sb_err", 32'(sb_err), 32'h0);
    req_valid = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      e.rdy = tbl[i].rdy; e.wen = tbl[i].wen; e.num = tbl[i].wnum; e.dat = tbl[i].wdat;
      exp_q.push_back(e);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL row%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(e.rdy));
        chk($sformatf("row%0d wr_en", i), 32'(wr_en), 32'(e.wen));
        chk($sformatf("row%0d wr_num", i), 32'(wr_num), 32'(e.num));
        chk($sformatf("row%0d wr_data", i), wr_data, e.dat);
      end
      chk($sformatf("row%0d hazard", i), 32'(hazard), 32'(tbl[i].haz));
      chk($sformatf("row%0d busy", i), busy_vec, tbl[i].busy);
      chk($sformatf("row%0d sb_err", i), 32'(sb_err), 32'(tbl[i].err));
    end

    // Mid-stream reset with x5 and x7 pending and the pointer at requester 1.
    @(posedge clk); #1;
    issue_en = 1'b0;
    chk("pre-reset busy", busy_vec, 32'h0000_00A0);
    chk("pre-reset ready", 32'(req_ready), 32'b010);
    chk("pre-reset sb_err", 32'(sb_err), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy_vec, 32'h0);
    chk("midreset ready", 32'(req_ready), 32'h0);
    chk("midreset wr_en", 32'(wr_en), 32'h0);
    chk("midreset wr_num", 32'(wr_num), 32'h0);
    chk("midreset wr_data", wr_data, 32'h0);
    chk("midreset sb_err", 32'(sb_err), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset ready", 32'(req_ready), 32'b001);
    chk("post-reset wr_num", 32'(wr_num), 32'd1);
    chk("post-reset wr_en", 32'(wr_en), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
